// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receive path
//
// Purpose: receiver state encoding, channel encoding of lrclk and the
// default word/slot geometry used by i2s_to_pcm_converter.
// Ports: none (package).
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } i2s_state_e;

  // lrclk level for each channel
  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_SLOT_BITS  = 32;

endpackage

// File: rtl/i2s_pin_sync.sv
// rtl/i2s_pin_sync.sv - pin synchronizers and bclk rise detector
//
// Purpose: brings bclk/lrclk/sdata into the clk domain through
// SYNC_STAGES flops each, plus one extra bclk flop for the rise detector.
// All three pins share the same delay, so lrclk_s/sdata_s are stable and
// aligned with bclk_rise.
// Ports:
//   clk, rst_n           fabric clock, async active-low reset
//   clr                  synchronous clear (receiver disabled)
//   bclk_in, lrclk_in,
//   sdata_in             raw asynchronous I2S pins
//   bclk_rise            one-clk pulse per synchronized bclk rising edge
//   lrclk_s, sdata_s     synchronized word select and data
module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic bclk_in,
  input  logic lrclk_in,
  input  logic sdata_in,
  output logic bclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);

  logic [SYNC_STAGES-1:0] bclk_sr;
  logic [SYNC_STAGES-1:0] lrclk_sr;
  logic [SYNC_STAGES-1:0] sdata_sr;
  logic                   bclk_d;
  logic                   bclk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sr  <= '0;
      lrclk_sr <= '0;
      sdata_sr <= '0;
      bclk_d   <= 1'b0;
    end else if (clr) begin
      bclk_sr  <= '0;
      lrclk_sr <= '0;
      sdata_sr <= '0;
      bclk_d   <= 1'b0;
    end else begin
      bclk_sr[0]  <= bclk_in;
      lrclk_sr[0] <= lrclk_in;
      sdata_sr[0] <= sdata_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        bclk_sr[i]  <= bclk_sr[i-1];
        lrclk_sr[i] <= lrclk_sr[i-1];
        sdata_sr[i] <= sdata_sr[i-1];
      end
      bclk_d <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sr[SYNC_STAGES-1];
  assign lrclk_s   = lrclk_sr[SYNC_STAGES-1];
  assign sdata_s   = sdata_sr[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_d;

endmodule

// File: rtl/i2s_to_pcm_converter.sv
// rtl/i2s_to_pcm_converter.sv - oversampled I2S receiver producing PCM words
//
// Purpose: recovers DATA_WIDTH-bit left/right words from an external I2S
// stream sampled in the clk domain, validates slot length, locks after
// LOCK_SLOTS good slots and emits one-clk l_data_en/r_data_en strobes.
// Ports:
//   clk, rst_n            fabric clock, async active-low reset
//   audio_en              synchronous enable; low clears everything
//   bclk_in, lrclk_in,
//   sdata_in              external I2S pins (asynchronous)
//   l_data, r_data        last captured left/right word
//   l_data_en, r_data_en  one-clk valid strobes
//   locked                receiver locked to the stream
//   frame_err             sticky malformed-slot / bclk-timeout flag
module i2s_to_pcm_converter
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int SLOT_BITS    = DEF_SLOT_BITS,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_SLOTS   = 4,
  parameter int BCLK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  audio_en,
  input  logic                  bclk_in,
  input  logic                  lrclk_in,
  input  logic                  sdata_in,
  output logic [DATA_WIDTH-1:0] l_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  l_data_en,
  output logic                  r_data_en,
  output logic                  locked,
  output logic                  frame_err
);

  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam int GW = $clog2(LOCK_SLOTS + 1);
  localparam int WW = $clog2(BCLK_TIMEOUT + 1);

  logic                  brise;
  logic                  lrclk_s;
  logic                  sdata_s;
  logic                  sync_clr;

  i2s_state_e            state, state_nxt;
  logic [GW-1:0]         good_cnt, good_nxt, good_inc;
  logic                  locked_nxt;
  logic                  err_nxt;

  logic                  lr_prev;
  logic [5:0]            slot_cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [WW-1:0]         wd_cnt;

  logic                  boundary;
  logic                  slot_good;
  logic                  timeout;
  logic                  word_done;
  logic [DATA_WIDTH-1:0] word_next;

  assign sync_clr = ~audio_en;

  i2s_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sync_clr),
    .bclk_in  (bclk_in),
    .lrclk_in (lrclk_in),
    .sdata_in (sdata_in),
    .bclk_rise(brise),
    .lrclk_s  (lrclk_s),
    .sdata_s  (sdata_s)
  );

  assign boundary  = brise && (lrclk_s != lr_prev);
  assign slot_good = (slot_cnt == 6'(SLOT_BITS));
  // Fires on the clk that would take the watchdog to BCLK_TIMEOUT; a brise
  // in the same cycle takes priority and restarts the count instead.
  assign timeout   = !brise && (wd_cnt >= WW'(BCLK_TIMEOUT - 1));
  // The boundary rise carries the previous slot's last bit, so only
  // non-boundary rises contribute data bits.
  assign word_done = brise && !boundary && (bit_idx == IW'(DATA_WIDTH - 1));
  assign word_next = {shreg[DATA_WIDTH-2:0], sdata_s};
  assign good_inc  = good_cnt + 1'b1;

  // Slot tracking, data shift register and bclk watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_prev  <= 1'b0;
      slot_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      wd_cnt   <= '0;
    end else if (!audio_en) begin
      lr_prev  <= 1'b0;
      slot_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      wd_cnt   <= '0;
    end else begin
      if (brise) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WW'(BCLK_TIMEOUT)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end

      if (brise) begin
        lr_prev <= lrclk_s;
        if (boundary) begin
          slot_cnt <= 6'd1;
          bit_idx  <= '0;
        end else begin
          if (slot_cnt != 6'd63) begin
            slot_cnt <= slot_cnt + 1'b1;
          end
          if (bit_idx < IW'(DATA_WIDTH)) begin
            shreg   <= word_next;
            bit_idx <= bit_idx + 1'b1;
          end
        end
      end
    end
  end

  // Output words: loaded straight from the completing shift so the strobe
  // follows the LSB-sampling rise by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_data    <= '0;
      r_data    <= '0;
      l_data_en <= 1'b0;
      r_data_en <= 1'b0;
    end else if (!audio_en) begin
      l_data    <= '0;
      r_data    <= '0;
      l_data_en <= 1'b0;
      r_data_en <= 1'b0;
    end else begin
      l_data_en <= 1'b0;
      r_data_en <= 1'b0;
      if (word_done && (state == LOCKED)) begin
        case (lrclk_s)
          CH_LEFT: begin
            l_data    <= word_next;
            l_data_en <= 1'b1;
          end
          CH_RIGHT: begin
            r_data    <= word_next;
            r_data_en <= 1'b1;
          end
        endcase
      end
    end
  end

  // Lock state machine: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      good_cnt  <= '0;
      locked    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      locked    <= locked_nxt;
      frame_err <= err_nxt;
    end
  end

  // Lock state machine: next state
  always_comb begin
    state_nxt  = state;
    good_nxt   = good_cnt;
    locked_nxt = locked;
    err_nxt    = frame_err;

    if (!audio_en) begin
      state_nxt  = IDLE;
      good_nxt   = '0;
      locked_nxt = 1'b0;
      err_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = HUNT;
        end
        HUNT: begin
          // The slot in progress at start-up is partial, so its length is
          // not judged; counting starts from the first boundary.
          if (boundary) begin
            good_nxt  = '0;
            state_nxt = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (timeout) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            state_nxt  = HUNT;
          end else if (boundary) begin
            if (slot_good) begin
              good_nxt = good_inc;
              if (good_inc == GW'(LOCK_SLOTS)) begin
                locked_nxt = 1'b1;
                state_nxt  = LOCKED;
              end
            end else begin
              err_nxt  = 1'b1;
              good_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (timeout) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            state_nxt  = HUNT;
          end else if (boundary && !slot_good) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            good_nxt   = '0;
            state_nxt  = ACQUIRE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_to_pcm_converter.sv
// tb/tb_i2s_to_pcm_converter.sv - self-checking bench for i2s_to_pcm_converter
//
// Purpose: drives an I2S stream at clk/8 bclk with 32-bit slots and checks
// captured words, strobe width, lock acquisition, slot errors, bclk
// timeout, audio_en clear and asynchronous reset.
module tb_i2s_to_pcm_converter;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          audio_en = 1'b0;
  logic          bclk_in = 1'b0;
  logic          lrclk_in = 1'b0;
  logic          sdata_in = 1'b0;
  logic [DW-1:0] l_data;
  logic [DW-1:0] r_data;
  logic          l_data_en;
  logic          r_data_en;
  logic          locked;
  logic          frame_err;

  always #5 clk = ~clk;

  i2s_to_pcm_converter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .audio_en (audio_en),
    .bclk_in  (bclk_in),
    .lrclk_in (lrclk_in),
    .sdata_in (sdata_in),
    .l_data   (l_data),
    .r_data   (r_data),
    .l_data_en(l_data_en),
    .r_data_en(r_data_en),
    .locked   (locked),
    .frame_err(frame_err)
  );

  int            errors = 0;
  int            checks = 0;
  int            l_cnt = 0;
  int            r_cnt = 0;
  logic [DW-1:0] exp_l = '0;
  logic [DW-1:0] exp_r = '0;
  logic          l_en_q = 1'b0;
  logic          r_en_q = 1'b0;

  typedef struct {
    logic [DW-1:0] l_word;
    logic [DW-1:0] r_word;
    logic          rpad;
    int            frames;
    logic [DW-1:0] exp_lw;
    logic [DW-1:0] exp_rw;
    int            exp_words;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Strobe monitor: value, width and lock qualification of every strobe
  always @(negedge clk) begin
    if (l_data_en) begin
      l_cnt++;
      chk("l_data", {8'h0, l_data}, {8'h0, exp_l});
      chk("l_en_width", {31'h0, l_en_q}, 32'h0);
      chk("l_en_locked", {31'h0, locked}, 32'h1);
    end
    if (r_data_en) begin
      r_cnt++;
      chk("r_data", {8'h0, r_data}, {8'h0, exp_r});
      chk("r_en_width", {31'h0, r_en_q}, 32'h0);
      chk("r_en_locked", {31'h0, locked}, 32'h1);
    end
    l_en_q = l_data_en;
    r_en_q = r_data_en;
  end

  // One bclk period (8 clk): data and lrclk change with the falling edge
  task automatic send_bit(input logic lr, input logic sd);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    sdata_in = sd;
    repeat (4) @(negedge clk);
    bclk_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Bits first..nbits-1 of a slot: bit 0 is the previous slot's tail,
  // bits 1..DW are the word MSB first, the rest is padding.
  task automatic send_slot(input logic lr, input logic [DW-1:0] word,
                           input int first, input int nbits, input logic rpad);
    logic b;
    for (int k = first; k < nbits; k++) begin
      if (k >= 1 && k <= DW) b = word[DW-k];
      else if (rpad) b = 1'($urandom_range(0, 1));
      else b = 1'b0;
      send_bit(lr, b);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] lw, input logic [DW-1:0] rw, input logic rpad);
    exp_l = lw;
    exp_r = rw;
    send_slot(1'b0, lw, 0, 32, rpad);
    send_slot(1'b1, rw, 0, 32, rpad);
  endtask

  // From HUNT: boundary at R, then L,R,L good; lock at the last R start
  task automatic relock(input logic [DW-1:0] lw, input logic [DW-1:0] rw);
    exp_l = lw;
    exp_r = rw;
    send_slot(1'b1, rw, 0, 32, 1'b0);
    send_frame(lw, rw, 1'b0);
    send_frame(lw, rw, 1'b0);
  endtask

  initial begin
    int l0;
    int r0;

    vecs[0] = '{24'h666AAA, 24'h555999, 1'b0, 2, 24'h666AAA, 24'h555999, 2};
    vecs[1] = '{24'h666AAA, 24'h555999, 1'b1, 3, 24'h666AAA, 24'h555999, 3};
    vecs[2] = '{24'h800001, 24'h7FFFFE, 1'b0, 2, 24'h800001, 24'h7FFFFE, 2};
    vecs[3] = '{24'hFFFFFF, 24'h000000, 1'b1, 2, 24'hFFFFFF, 24'h000000, 2};
    vecs[4] = '{24'h123456, 24'hABCDEF, 1'b1, 2, 24'h123456, 24'hABCDEF, 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_l_data", {8'h0, l_data}, 32'h0);
    chk("rst_r_data", {8'h0, r_data}, 32'h0);
    chk("rst_l_en", {31'h0, l_data_en}, 32'h0);
    chk("rst_r_en", {31'h0, r_data_en}, 32'h0);
    chk("rst_locked", {31'h0, locked}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    rst_n    = 1'b1;
    audio_en = 1'b1;
    @(negedge clk);

    // Acquisition: lock at the start of the third right slot
    for (int f = 0; f < 3; f++) send_frame(24'h666AAA, 24'h555999, 1'b0);
    chk("acq_locked", {31'h0, locked}, 32'h1);
    chk("acq_frame_err", {31'h0, frame_err}, 32'h0);
    chk("acq_l_cnt", l_cnt, 0);
    chk("acq_r_cnt", r_cnt, 1);

    // Table-driven word patterns
    for (int i = 0; i < NV; i++) begin
      l0 = l_cnt;
      r0 = r_cnt;
      for (int f = 0; f < vecs[i].frames; f++)
        send_frame(vecs[i].l_word, vecs[i].r_word, vecs[i].rpad);
      chk($sformatf("vec%0d_l_cnt", i), l_cnt - l0, vecs[i].exp_words);
      chk($sformatf("vec%0d_r_cnt", i), r_cnt - r0, vecs[i].exp_words);
      chk($sformatf("vec%0d_l_data", i), {8'h0, l_data}, {8'h0, vecs[i].exp_lw});
      chk($sformatf("vec%0d_r_data", i), {8'h0, r_data}, {8'h0, vecs[i].exp_rw});
      chk($sformatf("vec%0d_frame_err", i), {31'h0, frame_err}, 32'h0);
      chk($sformatf("vec%0d_locked", i), {31'h0, locked}, 32'h1);
    end

    // Shortened left slot (31 bclk) while locked
    exp_l = 24'h666AAA;
    exp_r = 24'h555999;
    l0 = l_cnt;
    send_slot(1'b0, 24'h666AAA, 0, 31, 1'b0);
    chk("short_word_emitted", l_cnt - l0, 1);
    l0 = l_cnt;
    r0 = r_cnt;
    send_bit(1'b1, 1'b0);
    chk("short_frame_err", {31'h0, frame_err}, 32'h1);
    chk("short_locked", {31'h0, locked}, 32'h0);
    send_slot(1'b1, 24'h555999, 1, 32, 1'b0);
    send_frame(24'h666AAA, 24'h555999, 1'b0);
    send_slot(1'b0, 24'h666AAA, 0, 32, 1'b0);
    chk("short_no_l", l_cnt - l0, 0);
    chk("short_no_r", r_cnt - r0, 0);
    chk("short_still_unlocked", {31'h0, locked}, 32'h0);
    send_slot(1'b1, 24'h555999, 0, 32, 1'b0);
    chk("short_relock", {31'h0, locked}, 32'h1);
    chk("short_relock_r", r_cnt - r0, 1);
    send_frame(24'h666AAA, 24'h555999, 1'b0);
    chk("short_after_l", l_cnt - l0, 1);

    // bclk stalls mid-slot for 100 clk
    l0 = l_cnt;
    r0 = r_cnt;
    send_slot(1'b0, 24'h666AAA, 0, 11, 1'b0);
    repeat (56) @(negedge clk);
    chk("stall_locked_early", {31'h0, locked}, 32'h1);
    repeat (10) @(negedge clk);
    chk("stall_locked_late", {31'h0, locked}, 32'h0);
    chk("stall_frame_err", {31'h0, frame_err}, 32'h1);
    repeat (30) @(negedge clk);
    relock(24'h666AAA, 24'h555999);
    chk("stall_relock", {31'h0, locked}, 32'h1);
    chk("stall_no_partial_l", l_cnt - l0, 0);
    chk("stall_relock_r", r_cnt - r0, 1);

    // audio_en dropped mid-word
    send_frame(24'h800001, 24'h7FFFFE, 1'b0);
    send_slot(1'b0, 24'h800001, 0, 11, 1'b0);
    audio_en = 1'b0;
    @(negedge clk);
    chk("aen_l_data", {8'h0, l_data}, 32'h0);
    chk("aen_r_data", {8'h0, r_data}, 32'h0);
    chk("aen_locked", {31'h0, locked}, 32'h0);
    chk("aen_frame_err", {31'h0, frame_err}, 32'h0);
    l0 = l_cnt;
    audio_en = 1'b1;
    send_slot(1'b0, 24'h800001, 11, 32, 1'b0);
    chk("aen_no_strobe", l_cnt - l0, 0);
    relock(24'h800001, 24'h7FFFFE);
    chk("aen_relock", {31'h0, locked}, 32'h1);
    chk("aen_relock_err", {31'h0, frame_err}, 32'h0);

    // Asynchronous reset between clk edges, mid-word
    send_slot(1'b0, 24'h800001, 0, 11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_l_data", {8'h0, l_data}, 32'h0);
    chk("arst_r_data", {8'h0, r_data}, 32'h0);
    chk("arst_locked", {31'h0, locked}, 32'h0);
    chk("arst_en", {30'h0, l_data_en, r_data_en}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    l0 = l_cnt;
    send_slot(1'b0, 24'h800001, 11, 32, 1'b0);
    chk("arst_no_strobe", l_cnt - l0, 0);
    chk("arst_frame_err", {31'h0, frame_err}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_to_pcm_converter.md
Name: i2s_to_pcm_converter

Overview:
- I2S receiver for the ADC/external-source input path. Recovers 24-bit left/right PCM words from an external I2S stream (bclk, lrclk, sdata are asynchronous to the fabric clock).
- Runs entirely in the 49.152 MHz clk domain. bclk is oversampled; nominal bclk is 6.144 MHz, i.e. 8 clk per bclk, with 64 bclk per frame at 96 kHz.
- Emits one-cycle l_data_en/r_data_en strobes with data, matching the PCM input side of the existing I2S transmit path, so the two blocks loop back directly.

Parameters:
- DATA_WIDTH, 24, PCM word width captured per slot.
- SLOT_BITS, 32, bclk periods per lrclk half-frame. Constraint: SLOT_BITS >= DATA_WIDTH+1 and SLOT_BITS <= 63.
- SYNC_STAGES, 2, synchronizer flops per input pin.
- LOCK_SLOTS, 4, consecutive well-formed slots required to declare lock.
- BCLK_TIMEOUT, 64, clk cycles without a bclk rise before lock is dropped.

Ports:
- clk  in  1  fabric clock, 49.152 MHz.
- rst_n  in  1  asynchronous active-low reset.
- audio_en  in  1  synchronous enable; low clears all state.
- bclk_in  in  1  external I2S bit clock (async).
- lrclk_in  in  1  external word select (async); 0 = left, 1 = right.
- sdata_in  in  1  external serial data (async), MSB first.
- l_data  out  DATA_WIDTH  last captured left word.
- r_data  out  DATA_WIDTH  last captured right word.
- l_data_en  out  1  one-clk strobe, l_data valid.
- r_data_en  out  1  one-clk strobe, r_data valid.
- locked  out  1  receiver locked to the stream.
- frame_err  out  1  sticky; a malformed slot or timeout was seen.

Behaviour:
- Reset (rst_n low, async): every output is 0, state = IDLE, and all counters and shift registers are 0. audio_en low gives the same result synchronously, on the next clk.
- Input conditioning:
  - bclk_in, lrclk_in and sdata_in each pass through SYNC_STAGES flops, plus one extra bclk flop for edge detection.
  - brise = bclk_s & ~bclk_d.
  - lrclk and sdata are sampled only on a brise cycle, so all three pins see identical sync delay.
- Slot tracking, on each brise:
  - lr_prev <= lrclk_s.
  - Boundary when lrclk_s != lr_prev. The boundary rise carries the previous slot's last bit and is discarded. The next rise carries the MSB (I2S one-bit delay).
  - slot_cnt: set to 1 on a boundary, otherwise incremented, saturating at 63.
  - At each boundary, the slot is good if slot_cnt == SLOT_BITS, else bad.
- Data capture:
  - bit_idx resets to 0 on a boundary.
  - On each non-boundary rise with bit_idx < DATA_WIDTH: shift sdata_s into the shift register LSB (MSB first), then bit_idx++.
  - Rises with bit_idx >= DATA_WIDTH are ignored, as are all padding bits.
  - When bit_idx reaches DATA_WIDTH-1 on a rise, the word is complete. The channel is taken from the lrclk_s sample.
  - On the next clk, if state == LOCKED: load l_data or r_data and pulse the matching en for exactly one clk.
  - Output registers hold their value between words. en never asserts outside LOCKED.
- State machine:
  - IDLE -> HUNT when audio_en = 1.
  - HUNT: waits for the first boundary. The partial first slot is not checked. good_cnt <= 0, then -> ACQUIRE.
  - ACQUIRE: a good boundary increments good_cnt. When good_cnt reaches LOCK_SLOTS -> LOCKED and locked <= 1 on the same clk. A bad boundary sets frame_err and good_cnt <= 0.
  - LOCKED: a bad boundary sets frame_err, clears locked and -> ACQUIRE with good_cnt = 0. The word in the bad slot, if already complete, has already been emitted; a word still incomplete at the boundary is discarded.
  - Timeout: a watchdog counts clk cycles since the last brise. Reaching BCLK_TIMEOUT in ACQUIRE or LOCKED sets frame_err, clears locked and -> HUNT. The watchdog is reset on every brise.
  - audio_en low in any state -> IDLE. frame_err is cleared only here or by rst_n.
- Latency: lrclk/sdata pin to capture is SYNC_STAGES+1 clk. The LSB-sampling brise cycle to en strobe is 1 clk.
- Boundary conditions:
  - A boundary on the same brise as bit_idx = DATA_WIDTH-1 is impossible by the parameter constraint.
  - Simultaneous timeout and brise: the brise wins and the watchdog resets.

Decomposition:
- Package i2s_pkg holds:
  - state encoding (IDLE, HUNT, ACQUIRE, LOCKED);
  - channel constants (CH_LEFT = 0, CH_RIGHT = 1);
  - default DATA_WIDTH and SLOT_BITS.
- One sub-module, i2s_pin_sync: SYNC_STAGES synchronizer for the 3 pins plus the bclk rise detector. Outputs bclk_rise, lrclk_s, sdata_s.

Test Plan:
1. Nominal stream, bclk = clk/8, 64 bclk per frame, L = 24'h666AAA, R = 24'h555999 repeated → locked rises after 4 good slots. Then l_data_en/r_data_en alternate, one each per frame, with exactly those values. Strobes are exactly 1 clk wide.
2. Padding bits 24..31 randomised every slot → captured words are unchanged, and frame_err stays 0.
3. Once locked, one left slot shortened to 31 bclk → frame_err = 1 and locked = 0 at that boundary. No strobes until 4 good slots pass, then relock with correct data.
4. bclk stopped mid-slot for 100 clk → locked falls 64 clk after the last brise and frame_err = 1. On restart: HUNT, then relock, with no partial word emitted.
5. audio_en dropped mid-word, then rst_n pulsed asynchronously between clk edges → all outputs 0 immediately (rst_n) or next clk (audio_en). frame_err cleared, and no strobe is emitted for the aborted word.
6. Data 24'h800001 (L) / 24'h7FFFFE (R) → correct MSB/LSB ordering, with no bit slip across the lrclk boundary.
